// File: rtl/dispensador_bebidas.sv
// -----------------------------------------------------------------------------
// dispensador_bebidas
// Actuator-side controller for the coffee machine. It decodes the 3-bit command
// bus driven by maquina_de_cafe and drives the powder valves, the water pump and
// the coin ejector with timed pulses. It also reports busy/done status back.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous reset, active high
//   cmd[2:0]        command code (000 NADA, 001 CAFE, 010 TE, 011 CAFE+cambio,
//                   100 TE+cambio, 101 DEVOLVER, 110/111 reserved)
//   valvula_cafe    coffee powder valve
//   valvula_te      tea powder valve
//   bomba_agua      water pump
//   expulsor_moneda coin/change ejector
//   ocupado         high while a sequence runs (POLVO, AGUA, MONEDA)
//   listo           one-cycle pulse when a sequence completes
//   error_cmd       one-cycle pulse on a reserved code while armed in IDLE
//   conteo[7:0]     beverages-served counter
//
// Optional feature: define DISPENSADOR_CONTADOR_EN to enable the saturating
// beverages-served counter. Without it, conteo is tied to zero.
// -----------------------------------------------------------------------------
module dispensador_bebidas #(
    parameter int unsigned T_POLVO  = 4,
    parameter int unsigned T_AGUA   = 8,
    parameter int unsigned T_MONEDA = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cmd,
    output logic       valvula_cafe,
    output logic       valvula_te,
    output logic       bomba_agua,
    output logic       expulsor_moneda,
    output logic       ocupado,
    output logic       listo,
    output logic       error_cmd,
    output logic [7:0] conteo
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POLVO  = 3'd1,
        AGUA   = 3'd2,
        MONEDA = 3'd3,
        FIN    = 3'd4,
        ESPERA = 3'd5
    } estado_t;

    estado_t    estado;
    logic [7:0] timer;
    logic       armado;
    logic       cambio;

    // Sequencer. All actuators and status flags are registered here, so each
    // actuator switches on the same edge as the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado          <= IDLE;
            timer           <= 8'd0;
            armado          <= 1'b0;
            cambio          <= 1'b0;
            valvula_cafe    <= 1'b0;
            valvula_te      <= 1'b0;
            bomba_agua      <= 1'b0;
            expulsor_moneda <= 1'b0;
            ocupado         <= 1'b0;
            listo           <= 1'b0;
            error_cmd       <= 1'b0;
        end else begin
            listo     <= 1'b0;
            error_cmd <= 1'b0;

            // A NADA code re-arms on any edge; acceptance below clears it.
            if (cmd == 3'b000) begin
                armado <= 1'b1;
            end

            case (estado)
                IDLE: begin
                    if (armado) begin
                        case (cmd)
                            3'b001, 3'b010, 3'b011, 3'b100: begin
                                estado       <= POLVO;
                                timer        <= 8'(T_POLVO - 1);
                                valvula_cafe <= (cmd == 3'b001) || (cmd == 3'b011);
                                valvula_te   <= (cmd == 3'b010) || (cmd == 3'b100);
                                cambio       <= (cmd == 3'b011) || (cmd == 3'b100);
                                ocupado      <= 1'b1;
                                armado       <= 1'b0;
                            end
                            3'b101: begin
                                estado          <= MONEDA;
                                timer           <= 8'(T_MONEDA - 1);
                                expulsor_moneda <= 1'b1;
                                cambio          <= 1'b0;
                                ocupado         <= 1'b1;
                                armado          <= 1'b0;
                            end
                            3'b110, 3'b111: begin
                                error_cmd <= 1'b1;
                                armado    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end

                POLVO: begin
                    if (timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end else begin
                        // Valve off and pump on in the same edge: no gap, no overlap.
                        estado       <= AGUA;
                        timer        <= 8'(T_AGUA - 1);
                        valvula_cafe <= 1'b0;
                        valvula_te   <= 1'b0;
                        bomba_agua   <= 1'b1;
                    end
                end

                AGUA: begin
                    if (timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end else begin
                        bomba_agua <= 1'b0;
                        if (cambio) begin
                            estado          <= MONEDA;
                            timer           <= 8'(T_MONEDA - 1);
                            expulsor_moneda <= 1'b1;
                        end else begin
                            estado  <= FIN;
                            ocupado <= 1'b0;
                            listo   <= 1'b1;
                        end
                    end
                end

                MONEDA: begin
                    if (timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end else begin
                        estado          <= FIN;
                        expulsor_moneda <= 1'b0;
                        ocupado         <= 1'b0;
                        listo           <= 1'b1;
                    end
                end

                FIN: begin
                    estado <= ESPERA;
                end

                ESPERA: begin
                    if (cmd == 3'b000) begin
                        estado <= IDLE;
                    end
                end

                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

`ifdef DISPENSADOR_CONTADOR_EN
    logic bebida;
    logic entra_fin_c;

    // The edge that moves the sequencer into FIN.
    assign entra_fin_c = ((estado == AGUA) && (timer == 8'd0) && !cambio) ||
                         ((estado == MONEDA) && (timer == 8'd0));

    // Remembers whether the running sequence served a drink (refunds don't count).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bebida <= 1'b0;
            conteo <= 8'd0;
        end else begin
            if ((estado == IDLE) && armado && (cmd >= 3'b001) && (cmd <= 3'b101)) begin
                bebida <= (cmd != 3'b101);
            end
            if (entra_fin_c && bebida && (conteo != 8'hFF)) begin
                conteo <= conteo + 8'd1;
            end
        end
    end
`else
    assign conteo = 8'd0;
`endif

endmodule

// File: tb/tb_dispensador_bebidas.sv
module tb_dispensador_bebidas;

    logic       clk;
    logic       rst;
    logic [2:0] cmd;
    logic       valvula_cafe;
    logic       valvula_te;
    logic       bomba_agua;
    logic       expulsor_moneda;
    logic       ocupado;
    logic       listo;
    logic       error_cmd;
    logic [7:0] conteo;

    dispensador_bebidas dut (
        .clk             (clk),
        .rst             (rst),
        .cmd             (cmd),
        .valvula_cafe    (valvula_cafe),
        .valvula_te      (valvula_te),
        .bomba_agua      (bomba_agua),
        .expulsor_moneda (expulsor_moneda),
        .ocupado         (ocupado),
        .listo           (listo),
        .error_cmd       (error_cmd),
        .conteo          (conteo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {cafe, te, bomba, moneda, ocupado, listo, error_cmd}
    localparam logic [6:0] V_0     = 7'b0000000;
    localparam logic [6:0] V_CAFE  = 7'b1000100;
    localparam logic [6:0] V_TE    = 7'b0100100;
    localparam logic [6:0] V_AGUA  = 7'b0010100;
    localparam logic [6:0] V_MON   = 7'b0001100;
    localparam logic [6:0] V_LISTO = 7'b0000010;
    localparam logic [6:0] V_ERR   = 7'b0000001;

    logic [6:0] salidas;
    assign salidas = {valvula_cafe, valvula_te, bomba_agua, expulsor_moneda,
                      ocupado, listo, error_cmd};

    typedef struct {
        logic [2:0] code;
        int         nc;   // coffee valve cycles
        int         nt;   // tea valve cycles
        int         na;   // pump cycles
        int         nm;   // ejector cycles
        logic       err;  // reserved code
    } vec_t;

    vec_t       tabla[8];
    logic [6:0] exp_q[$];
    int         n_vec;
    int         n_err;
    int         exp_cnt;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
        end
    endtask

    task automatic push(input logic [6:0] v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    // Pops one expected vector per cycle and compares on the falling edge.
    task automatic drain(input string name);
        logic [6:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk(name, {1'b0, salidas}, {1'b0, e});
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        @(posedge clk); #1 cmd = 3'b000;
        @(posedge clk); #1 cmd = v.code;
        push(V_0, 1);                 // cycle before the accepting edge
        if (v.err) begin
            push(V_ERR, 1);
            push(V_0, 3);             // held reserved code: nothing more
        end else begin
            push(V_CAFE, v.nc);
            push(V_TE, v.nt);
            push(V_AGUA, v.na);
            push(V_MON, v.nm);
            push(V_LISTO, 1);
            push(V_0, 4);             // ESPERA with code still held
        end
        drain(name);
`ifdef DISPENSADOR_CONTADOR_EN
        if (!v.err && (v.code != 3'b101) && (exp_cnt < 255)) exp_cnt++;
`endif
        chk({name, "_conteo"}, conteo, 8'(exp_cnt));
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        exp_cnt = 0;

        tabla[0] = '{3'b001, 4, 0, 8, 0, 1'b0};
        tabla[1] = '{3'b010, 0, 4, 8, 0, 1'b0};
        tabla[2] = '{3'b011, 4, 0, 8, 2, 1'b0};
        tabla[3] = '{3'b100, 0, 4, 8, 2, 1'b0};
        tabla[4] = '{3'b101, 0, 0, 0, 2, 1'b0};
        tabla[5] = '{3'b110, 0, 0, 0, 0, 1'b1};
        tabla[6] = '{3'b111, 0, 0, 0, 0, 1'b1};
        tabla[7] = '{3'b001, 4, 0, 8, 0, 1'b0};

        // Reset with TE held on the bus: must not dispense until NADA is seen.
        rst = 1'b1;
        cmd = 3'b010;
        #2;
        chk("reset_out", {1'b0, salidas}, 8'd0);
        chk("reset_conteo", conteo, 8'd0);
        @(posedge clk); #1 rst = 1'b0;
        push(V_0, 5);
        drain("held_010_after_reset");

        for (int i = 0; i < 8; i++) begin
            run_vec(tabla[i], $sformatf("vec%0d_code%0d", i, tabla[i].code));
        end

        // Reset asserted while the pump runs (cycle 6 of a coffee sequence).
        @(posedge clk); #1 cmd = 3'b000;
        @(posedge clk); #1 cmd = 3'b001;
        push(V_0, 1);
        push(V_CAFE, 4);
        push(V_AGUA, 2);
        drain("pre_reset_coffee");
        #1 rst = 1'b1;
        #1;
        chk("async_reset_out", {1'b0, salidas}, 8'd0);
        exp_cnt = 0;
        chk("async_reset_conteo", conteo, 8'd0);
        @(posedge clk); #1 rst = 1'b0;
        push(V_0, 4);                 // disarmed: held 001 ignored
        drain("held_001_after_reset");
        run_vec(tabla[0], "coffee_after_reset");

`ifdef DISPENSADOR_CONTADOR_EN
        for (int i = 0; i < 256; i++) begin
            run_vec(tabla[0], "saturate");
        end
        chk("conteo_saturated", conteo, 8'd255);
        run_vec(tabla[4], "refund_at_sat");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
